qr_result_serializer: RTL and testbench

Output-side companion of the QR decomposition block. It acts as the consumer end of the QR block's `ready_out`/`accept_in` result handshake. Each 512-bit {Q,R} result is captured into a small FIFO and serialized as a narrow, element-wise valid/ready stream for the downstream ZF back-substitution and matrix-multiply stages. This decouples QR throughput from downstream backpressure.

---
 rtl/qr_result_serializer.sv | 101 ++++++++++
 tb/tb_qr_result_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_result_serializer.sv
// qr_result_serializer: buffers {Q,R} results from the QR block in a frame FIFO and streams them one element per word.
// Define QR_SER_HEADER_EN to prefix each frame with a {8'hA5, frame_cnt} header word.
module qr_result_serializer #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 16,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     ready_in,
    output logic                     accept_out,
    input  logic [ELEM_W*N_ELEM-1:0] Q_matrix_in,
    input  logic [ELEM_W*N_ELEM-1:0] R_matrix_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic                     out_sel,
    output logic                     out_last
);
    localparam int MW = ELEM_W * N_ELEM;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(N_ELEM);
`ifdef QR_SER_HEADER_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif
    localparam int LAST = 2 * N_ELEM - 1 + HOFF;
    localparam int IW = $clog2(LAST + 1);

    logic [MW-1:0]     q_mem [DEPTH];
    logic [MW-1:0]     r_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     idx_q, idx_d, eidx;
    logic [KW-1:0]     k;
    logic              push, pop, xfer, is_last, is_r, is_hdr;
    logic [ELEM_W-1:0] elem, hdr_word;
`ifdef QR_SER_HEADER_EN
    logic [7:0]        frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        // reset_n gating keeps accept_out low during reset even though count is already 0
        accept_out = reset_n & enable & (count_q < CW'(DEPTH));
        push       = ready_in & accept_out;
        out_valid  = (count_q != '0);
        xfer       = out_valid & out_ready;
        is_last    = (idx_q == IW'(LAST));
        pop        = xfer & is_last;
        out_last   = out_valid & is_last;
        eidx       = idx_q - IW'(HOFF);
        is_r       = (eidx >= IW'(N_ELEM));
        k          = KW'(is_r ? eidx - IW'(N_ELEM) : eidx);
        elem       = is_r ? r_mem[rd_ptr_q][k*ELEM_W +: ELEM_W] : q_mem[rd_ptr_q][k*ELEM_W +: ELEM_W];
`ifdef QR_SER_HEADER_EN
        is_hdr      = (idx_q == '0);
        hdr_word    = ELEM_W'({8'hA5, frame_cnt_q});
        frame_cnt_d = frame_cnt_q + 8'(pop);
`else
        is_hdr      = 1'b0;
        hdr_word    = '0;
`endif
        out_sel    = out_valid & is_r & ~is_hdr;
        out_data   = out_valid ? (is_hdr ? hdr_word : elem) : '0;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        idx_d      = xfer ? (is_last ? '0 : idx_q + 1'b1) : idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idx_q       <= '0;
`ifdef QR_SER_HEADER_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
`ifdef QR_SER_HEADER_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= Q_matrix_in;
            r_mem[wr_ptr_q] <= R_matrix_in;
        end
    end
endmodule

// File: tb/tb_qr_result_serializer.sv
// tb_qr_result_serializer: randomized checks of qr_result_serializer against a frame-queue reference model.
module tb_qr_result_serializer;
    localparam int EW = 16;
    localparam int NE = 16;
    localparam int DEPTH = 2;
    localparam int MW = EW * NE;
`ifdef QR_SER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int LEN = 2 * NE + HDR;

    logic clk = 0, reset_n = 0, enable = 0, ready_in = 0, out_ready = 0;
    logic [MW-1:0] q_in = '0, r_in = '0;
    logic accept_out, out_valid, out_sel, out_last;
    logic [EW-1:0] out_data;
    logic [19:0] dut_vec;

    int vectors = 0, fails = 0;
    logic [MW-1:0] mq[$], mr[$];
    int pos = 0, pops = 0;
    logic [7:0] fcnt = 0;

    always #5 clk = ~clk;
    assign dut_vec = {accept_out, out_valid, out_sel, out_last, out_data};

    qr_result_serializer #(.ELEM_W(EW), .N_ELEM(NE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ready_in(ready_in),
        .accept_out(accept_out), .Q_matrix_in(q_in), .R_matrix_in(r_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last)
    );

    // Expected {accept, valid, sel, last, data} from the queue of stored frames and the word position.
    function automatic logic [19:0] exp_out();
        logic acc, v, s, l;
        logic [15:0] d;
        logic [MW-1:0] fq, fr;
        int w;
        acc = reset_n && enable && (mq.size() < DEPTH);
        v = (mq.size() != 0);
        s = 0; l = 0; d = 0;
        if (v) begin
            fq = mq[0];
            fr = mr[0];
            l = (pos == LEN - 1);
            if (HDR == 1 && pos == 0) d = {8'hA5, fcnt};
            else begin
                w = pos - HDR;
                s = (w >= NE);
                d = s ? fr[(w-NE)*EW +: EW] : fq[w*EW +: EW];
            end
        end
        return {acc, v, s, l, d};
    endfunction

    function automatic void model_step();
        logic acc, v;
        acc = reset_n && enable && (mq.size() < DEPTH);
        v = (mq.size() != 0);
        if (v && out_ready) begin
            if (pos == LEN - 1) begin
                void'(mq.pop_front());
                void'(mr.pop_front());
                pos = 0;
                fcnt++;
                pops++;
            end else pos++;
        end
        if (acc && ready_in) begin
            mq.push_back(q_in);
            mr.push_back(r_in);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        mr.delete();
        pos = 0;
        fcnt = 0;
        pops = 0;
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < MW / 32; i++) begin
            q_in[i*32 +: 32] = $urandom;
            r_in[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic pattern_frame();
        for (int i = 0; i < NE; i++) begin
            q_in[i*EW +: EW] = 16'(16'h0100 + i);
            r_in[i*EW +: EW] = 16'(16'h0200 + i);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 0; enable = 1; ready_in = 1; out_ready = 1;
        rand_frame();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (dut_vec !== 20'h0) begin
                fails++;
                $display("FAIL reset cyc %0d: got %h expected %h", c, dut_vec, 20'h0);
            end
            model_step();
            @(negedge clk);
        end
        reset_n = 1; ready_in = 0;
    endtask

    task automatic test_single();
        int lasts = 0;
        pattern_frame();
        enable = 1; ready_in = 1; out_ready = 1;
        for (int c = 0; c < LEN + 4; c++) begin
            if (c == 1) ready_in = 0;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL single cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            if (out_valid && out_ready && out_last) lasts++;
            model_step();
            @(negedge clk);
        end
        vectors++;
        if (lasts !== 1) begin
            fails++;
            $display("FAIL single_lasts: got %0d expected 1", lasts);
        end
    endtask

    task automatic test_full();
        int nf = 0, lasts = 0, c = 0;
        logic cap;
        rand_frame();
        out_ready = 0; ready_in = 1; enable = 1;
        while (c < 300 && (nf < 3 || mq.size() != 0)) begin
            if (c == 8) out_ready = 1;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL full cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            if (out_valid && out_ready && out_last) lasts++;
            cap = ready_in && enable && reset_n && (mq.size() < DEPTH);
            model_step();
            @(negedge clk);
            if (cap) begin
                nf++;
                rand_frame();
                if (nf == 3) ready_in = 0;
            end
            c++;
        end
        vectors++;
        if (lasts !== 3) begin
            fails++;
            $display("FAIL full_frames: got %0d expected 3", lasts);
        end
    endtask

    task automatic test_toggle();
        int xfers = 0;
        logic [19:0] prev = '0;
        logic hold = 0;
        rand_frame();
        ready_in = 1; enable = 1; out_ready = 0;
        for (int c = 0; c < 2 * LEN + 3; c++) begin
            if (c == 1) ready_in = 0;
            out_ready = c[0];
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL toggle cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            if (hold) begin
                vectors++;
                if (dut_vec[16:0] !== prev[16:0]) begin
                    fails++;
                    $display("FAIL toggle_stable cyc %0d: got %h expected %h", c, dut_vec[16:0], prev[16:0]);
                end
            end
            hold = out_valid && !out_ready;
            prev = dut_vec;
            if (out_valid && out_ready) xfers++;
            model_step();
            @(negedge clk);
        end
        vectors++;
        if (xfers !== LEN) begin
            fails++;
            $display("FAIL toggle_xfers: got %0d expected %0d", xfers, LEN);
        end
        out_ready = 0;
    endtask

    task automatic test_enable();
        int lasts = 0;
        rand_frame();
        ready_in = 1; enable = 1; out_ready = 0;
        for (int c = 0; c < LEN + 12; c++) begin
            if (c == 1) begin
                enable = 0;
                rand_frame();
            end
            if (c == 3) out_ready = 1;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL enable cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            if (out_valid && out_ready && out_last) lasts++;
            model_step();
            @(negedge clk);
        end
        vectors++;
        if (lasts !== 1) begin
            fails++;
            $display("FAIL enable_frames: got %0d expected 1", lasts);
        end
        ready_in = 0; enable = 1;
    endtask

    task automatic test_reset_mid();
        pattern_frame();
        ready_in = 1; enable = 1; out_ready = 1;
        for (int c = 0; c < 60 && pos != 10; c++) begin
            if (c == 1) ready_in = 0;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL rst_mid_pre cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            model_step();
            @(negedge clk);
        end
        ready_in = 1;
        reset_n = 0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec !== 20'h0) begin
            fails++;
            $display("FAIL rst_mid_async: got %h expected %h", dut_vec, 20'h0);
        end
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < LEN + 4; c++) begin
            if (c == 1) ready_in = 0;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL rst_mid_post cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_frame();
            enable = ($urandom_range(0, 9) != 0);
            ready_in = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL random cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            model_step();
            @(negedge clk);
        end
        ready_in = 0; enable = 1; out_ready = 1;
    endtask

`ifdef QR_SER_HEADER_EN
    task automatic test_header();
        int lasts = 0;
        reset_n = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1; enable = 1; ready_in = 1; out_ready = 1;
        for (int c = 0; c < 10000 && pops < 257; c++) begin
            rand_frame();
            #1;
            vectors++;
            if (dut_vec !== exp_out()) begin
                fails++;
                $display("FAIL header cyc %0d: got %h expected %h", c, dut_vec, exp_out());
            end
            if (out_valid && out_ready && out_last) lasts++;
            model_step();
            @(negedge clk);
        end
        vectors++;
        if (lasts !== 257) begin
            fails++;
            $display("FAIL header_frames: got %0d expected 257", lasts);
        end
        ready_in = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_toggle();
        test_enable();
        test_reset_mid();
        test_random();
`ifdef QR_SER_HEADER_EN
        test_header();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
